// File: rtl/mole_pkg.sv
// rtl/mole_pkg.sv - shared types and constants for the whack-a-mole sequencer
package mole_pkg;

  typedef enum logic [2:0] {IDLE, SPAWN, SHOW, HIT, GAP, OVER} state_t;

  localparam logic [3:0] POS_NONE  = 4'd0;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // x^8+x^6+x^5+x^4+1 as taps on bits 7,5,4,3 of a left-shifting register
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] SCORE_MAX = 8'd255;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == SCORE_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mole_lfsr.sv
// rtl/mole_lfsr.sv - free-running 8-bit Fibonacci LFSR for mole placement
module mole_lfsr
  import mole_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] lfsr
);

  always_ff @(posedge clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
  end

endmodule

// File: rtl/mole_game_ctrl.sv
// rtl/mole_game_ctrl.sv - game sequencer: tick prescaler, mole FSM, score and timer
module mole_game_ctrl
  import mole_pkg::*;
#(
  parameter int TICK_DIV   = 12_500_000,
  parameter int SHOW_TICKS = 4,
  parameter int HIT_TICKS  = 2,
  parameter int GAP_TICKS  = 1,
  parameter int GAME_TICKS = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       in_game,
  output logic [3:0] position,
  output logic       hit,
  output logic [7:0] score,
  output logic [7:0] time_left,
  output logic       game_over
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_t        state, state_d;
  logic [CW-1:0] presc;
  logic          tick;
  logic          start_ok;
  logic [7:0]    lfsr;
  logic [3:0]    cand;
  logic [3:0]    last_pos, last_d, pos_d;
  logic          hit_d;
  logic [7:0]    score_d, time_d, phase, phase_d;
  logic          unused_lfsr_hi;

  mole_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lfsr (lfsr)
  );

  assign tick           = (presc == CW'(TICK_DIV - 1));
  assign cand           = lfsr[3:0] + 4'd1;
  assign unused_lfsr_hi = ^lfsr[7:4];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      presc     <= '0;
      position  <= POS_NONE;
      last_pos  <= POS_NONE;
      hit       <= 1'b0;
      score     <= 8'd0;
      time_left <= 8'd0;
      phase     <= 8'd0;
      in_game   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_d;
      presc     <= (start_ok || tick) ? '0 : presc + CW'(1);
      position  <= pos_d;
      last_pos  <= last_d;
      hit       <= hit_d;
      score     <= score_d;
      time_left <= time_d;
      phase     <= phase_d;
      in_game   <= (state_d inside {SPAWN, SHOW, HIT, GAP});
      game_over <= (state_d == OVER);
    end
  end

  always_comb begin
    state_d  = state;
    pos_d    = position;
    last_d   = last_pos;
    hit_d    = hit;
    score_d  = score;
    time_d   = time_left;
    phase_d  = phase;
    start_ok = 1'b0;
    case (state)
      IDLE, OVER: begin
        if (start) begin
          start_ok = 1'b1;
          state_d  = SPAWN;
          score_d  = 8'd0;
          time_d   = 8'(GAME_TICKS);
          last_d   = POS_NONE;
        end
      end
      default: begin
        // Game-timer expiry overrides everything else, including a scoring key.
        if (tick && time_left == 8'd1) begin
          state_d = OVER;
          time_d  = 8'd0;
          pos_d   = POS_NONE;
          hit_d   = 1'b0;
        end else begin
          if (tick) time_d = time_left - 8'd1;
          case (state)
            SPAWN: begin
              if ((lfsr[3:0] <= 4'd8) && (cand != last_pos)) begin
                pos_d   = cand;
                last_d  = cand;
                phase_d = 8'(SHOW_TICKS);
                state_d = SHOW;
              end
            end
            SHOW: begin
              if (key_valid && key_code == position) begin
                hit_d   = 1'b1;
                score_d = sat_inc(score);
                phase_d = 8'(HIT_TICKS);
                state_d = HIT;
              end else if (tick) begin
                if (phase == 8'd1) begin
                  pos_d   = POS_NONE;
                  phase_d = 8'(GAP_TICKS);
                  state_d = GAP;
                end else if (phase > 8'd1) begin
                  phase_d = phase - 8'd1;
                end
              end
            end
            HIT: begin
              if (tick) begin
                if (phase == 8'd1) begin
                  hit_d   = 1'b0;
                  pos_d   = POS_NONE;
                  phase_d = 8'(GAP_TICKS);
                  state_d = GAP;
                end else if (phase > 8'd1) begin
                  phase_d = phase - 8'd1;
                end
              end
            end
            GAP: begin
              if (tick) begin
                if (phase == 8'd1)     state_d = SPAWN;
                else if (phase > 8'd1) phase_d = phase - 8'd1;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

endmodule

// File: tb/tb_mole_game_ctrl.sv
// tb/tb_mole_game_ctrl.sv - directed self-checking bench for mole_game_ctrl
module tb_mole_game_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start_s = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;

  logic       in_game, hit, game_over;
  logic [3:0] position;
  logic [7:0] score, time_left;
  logic       in_game_s, hit_s, game_over_s;
  logic [3:0] position_s;
  logic [7:0] score_s, time_left_s;

  int checks = 0;
  int errors = 0;
  int n = 0;

  always #5 clk = ~clk;

  mole_game_ctrl #(
    .TICK_DIV(4), .SHOW_TICKS(3), .HIT_TICKS(1), .GAP_TICKS(1), .GAME_TICKS(20)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .key_valid(key_valid), .key_code(key_code),
    .in_game(in_game), .position(position), .hit(hit), .score(score),
    .time_left(time_left), .game_over(game_over)
  );

  // Long game used for the score saturation run.
  mole_game_ctrl #(
    .TICK_DIV(4), .SHOW_TICKS(3), .HIT_TICKS(1), .GAP_TICKS(1), .GAME_TICKS(255)
  ) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .key_valid(key_valid), .key_code(key_code),
    .in_game(in_game_s), .position(position_s), .hit(hit_s), .score(score_s),
    .time_left(time_left_s), .game_over(game_over_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task step();
    @(negedge clk);
    n++;
  endtask

  // Ticks land on posedges 4,8,... after the start edge; visible one negedge later.
  function automatic int exp_time(input int k);
    return 20 - (k - 1) / 4;
  endfunction

  int         p1, p2, c, t, r, sc, wd, expsc, lastp;
  logic [3:0] prev_pos, wrong;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_outputs", {in_game, position, hit, score, time_left, game_over}, 0);
    chk("reset_outputs_s", {in_game_s, position_s, hit_s, score_s, time_left_s, game_over_s}, 0);
    for (int i = 0; i < 50; i++) begin
      key_valid = 1'b1;
      key_code  = 4'(i % 9 + 1);
      @(negedge clk);
      chk("idle_quiet", {in_game, position, hit, score, time_left, game_over}, 0);
    end
    key_valid = 1'b0;

    // Game 1: start, first mole hit
    start = 1'b1; n = 0;
    step();
    start = 1'b0;
    chk("start_in_game", in_game, 1);
    chk("start_time", time_left, 20);
    chk("start_score", score, 0);
    chk("start_position", position, 0);
    chk("start_game_over", game_over, 0);
    while (position == 0 && n < 40) step();
    chk("mole1_appears", position != 0, 1);
    p1 = position;
    key_valid = 1'b1; key_code = position;
    t = ((n / 4) + 1) * 4;
    step();
    key_valid = 1'b0;
    chk("hit_flag", hit, 1);
    chk("hit_score", score, 1);
    chk("hit_position", position, p1);
    chk("hit_time", time_left, exp_time(n));
    while (n < t) step();
    chk("hit_held", hit, 1);
    step();
    chk("hit_cleared", hit, 0);
    chk("hit_pos_cleared", position, 0);

    // Second mole: wrong key, then timeout on the third tick
    wd = 0;
    while (position == 0 && wd < 40) begin step(); wd++; end
    chk("mole2_appears", position != 0, 1);
    p2 = position;
    chk("mole2_differs", p2 != p1, 1);
    c = n - 1;
    wrong = (position == 4'd9) ? 4'd1 : position + 4'd1;
    key_valid = 1'b1; key_code = wrong;
    step();
    key_valid = 1'b0;
    chk("miss_no_hit", hit, 0);
    chk("miss_score", score, 1);
    chk("miss_position", position, p2);
    t = ((c / 4) + 3) * 4;
    while (n < t) step();
    chk("miss_still_up", position, p2);
    step();
    chk("miss_timeout", position, 0);
    chk("miss_time", time_left, exp_time(n));

    // Play on, hitting moles that would otherwise outlive the game
    lastp = p2; prev_pos = position;
    while (n < 80) begin
      step();
      key_valid = 1'b0;
      if (prev_pos == 0 && position != 0) begin
        chk("g1_no_repeat", position != 4'(lastp), 1);
        lastp = position;
        r = 20 - (n - 1) / 4;
        if (r >= 4) begin
          key_valid = 1'b1; key_code = position;
        end
      end
      prev_pos = position;
    end
    chk("pre_end_in_game", in_game, 1);
    chk("pre_end_time", time_left, 1);
    chk("pre_end_over", game_over, 0);
    sc = score;
    if (position != 0 && hit == 0) begin
      key_valid = 1'b1; key_code = position;
    end
    step();
    key_valid = 1'b0;
    chk("end_in_game", in_game, 0);
    chk("end_game_over", game_over, 1);
    chk("end_time", time_left, 0);
    chk("end_position", position, 0);
    chk("end_hit", hit, 0);
    chk("end_score_kept", score, sc);
    repeat (8) step();
    chk("over_holds", {game_over, in_game, time_left}, {1'b1, 1'b0, 8'd0});

    // Restart from OVER, then reset mid-SHOW
    start = 1'b1; n = 0;
    step();
    start = 1'b0;
    chk("restart_score", score, 0);
    chk("restart_time", time_left, 20);
    chk("restart_in_game", in_game, 1);
    chk("restart_over", game_over, 0);
    while (position == 0 && n < 40) step();
    chk("restart_mole", position != 0, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midgame_reset", {in_game, position, hit, score, time_left, game_over}, 0);
    step();
    chk("reset_stays_idle", {in_game, position, hit, score, time_left, game_over}, 0);

    // Saturation run on the long-game instance
    start_s = 1'b1;
    step();
    start_s = 1'b0;
    chk("sat_start_time", time_left_s, 255);
    expsc = 0; lastp = 0;
    for (int m = 0; m < 60; m++) begin
      wd = 0;
      while (position_s == 0 && wd < 60) begin step(); wd++; end
      chk("sat_mole_appears", position_s != 0, 1);
      if (position_s == 0) break;
      chk("sat_range", (position_s >= 4'd1 && position_s <= 4'd9), 1);
      chk("sat_no_repeat", position_s != 4'(lastp), 1);
      lastp = position_s;
      if (m == 10) begin
        force dut_s.score = 8'd250;
        step();
        release dut_s.score;
        step();
        expsc = 250;
        chk("sat_preload", score_s, expsc);
      end
      key_valid = 1'b1; key_code = position_s;
      step();
      key_valid = 1'b0;
      expsc = (expsc == 255) ? 255 : expsc + 1;
      chk("sat_hit_pulse", hit_s, 1);
      chk("sat_score", score_s, expsc);
      wd = 0;
      while (hit_s == 1'b1 && wd < 10) begin step(); wd++; end
      chk("sat_hit_drops", {hit_s, position_s}, 0);
    end
    chk("sat_final", score_s, 255);
    chk("sat_still_running", in_game_s, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
